// File: rtl/inst_prefetch_queue_pkg.sv
// rtl/inst_prefetch_queue_pkg.sv - shared widths, defaults, state encoding and entry type
package inst_prefetch_queue_pkg;

  localparam int WORD_SIZE      = 32;
  localparam int PREFETCH_DEPTH = 4;
  localparam logic [WORD_SIZE-1:0] DEFAULT_RESET_PTR = '0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DRAIN = 2'd3
  } pq_state_e;

  typedef struct packed {
    logic [WORD_SIZE-1:0] ptr;
    logic [WORD_SIZE-1:0] inst;
  } pq_entry_t;

  // Pointer arithmetic wraps silently at 2^WORD_SIZE.
  function automatic logic [WORD_SIZE-1:0] ptr_advance(
    input logic [WORD_SIZE-1:0] ptr,
    input logic [WORD_SIZE-1:0] step
  );
    return ptr + step;
  endfunction

endpackage

// File: rtl/inst_prefetch_queue_fifo.sv
// rtl/inst_prefetch_queue_fifo.sv - synchronous {ptr, inst} FIFO with flush priority
module inst_prefetch_queue_fifo
  import inst_prefetch_queue_pkg::*;
#(
  parameter  int DEPTH = PREFETCH_DEPTH,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  pq_entry_t     push_entry,
  input  logic          pop,
  input  logic          flush,
  output pq_entry_t     head,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  pq_entry_t     mem_q [DEPTH];
  pq_entry_t     mem_d [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == DEPTH_C);
  assign count = count_q;
  assign head  = mem_q[rd_q];

  // Next-state of storage and pointers; flush wins over any push or pop.
  always_comb begin
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    if (flush) begin
      wr_d    = '0;
      rd_d    = '0;
      count_d = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_q] = push_entry;
        wr_d        = wr_q + 1'b1;
      end
      if (do_pop) begin
        rd_d = rd_q + 1'b1;
      end
      unique case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Storage and pointer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/inst_prefetch_queue.sv
// rtl/inst_prefetch_queue.sv - fetch pointer FSM feeding a small instruction queue for decode
module inst_prefetch_queue
  import inst_prefetch_queue_pkg::*;
#(
  parameter int                   DEPTH     = PREFETCH_DEPTH,
  parameter int unsigned          PTR_STEP  = 1,
  parameter logic [WORD_SIZE-1:0] RESET_PTR = DEFAULT_RESET_PTR
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic [0:WORD_SIZE-1] fetch_ptr,
  output logic                 fetch_enable,
  input  logic                 fetch_busy,
  input  logic [WORD_SIZE-1:0] fetch_inst,
  input  logic                 redirect,
  input  logic [WORD_SIZE-1:0] redirect_ptr,
  output logic [WORD_SIZE-1:0] inst_out,
  output logic [WORD_SIZE-1:0] inst_ptr,
  output logic                 inst_valid,
  input  logic                 inst_ready
);

  localparam int                   CW      = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0]        DEPTH_C = CW'(DEPTH);
  localparam logic [WORD_SIZE-1:0] STEP_W  = WORD_SIZE'(PTR_STEP);

  pq_state_e            state_q, state_d;
  logic [WORD_SIZE-1:0] next_ptr_q, next_ptr_d;
  logic                 fifo_push;
  logic                 fifo_full, fifo_empty;
  logic [CW-1:0]        fifo_count;
  logic [CW-1:0]        count_after;
  logic                 pop_fire;
  pq_entry_t            push_entry;
  pq_entry_t            head;

  assign inst_valid   = !fifo_empty;
  assign pop_fire     = inst_valid && inst_ready;
  assign inst_out     = head.inst;
  assign inst_ptr     = head.ptr;
  assign fetch_ptr    = next_ptr_q;
  assign fetch_enable = (state_q == ST_REQ);
  assign push_entry   = '{ptr: next_ptr_q, inst: fetch_inst};

  // Occupancy after a capture this cycle, net of a same-cycle pop.
  assign count_after  = fifo_count + CW'(1) - CW'(pop_fire);

  // Next state, capture strobe and next pointer; redirect overrides everything.
  always_comb begin
    state_d    = state_q;
    next_ptr_d = next_ptr_q;
    fifo_push  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_full) state_d = ST_REQ;
      end
      ST_REQ: begin
        if (fetch_busy) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (!fetch_busy) begin
          fifo_push  = 1'b1;
          next_ptr_d = ptr_advance(next_ptr_q, STEP_W);
          state_d    = (count_after < DEPTH_C) ? ST_REQ : ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (!fetch_busy) state_d = ST_REQ;
      end
      default: state_d = ST_IDLE;
    endcase

    if (redirect) begin
      fifo_push  = 1'b0;
      next_ptr_d = redirect_ptr;
      unique case (state_q)
        ST_IDLE:          state_d = ST_REQ;
        ST_REQ, ST_WAIT:  state_d = (fetch_busy || state_q == ST_WAIT) ? ST_DRAIN : ST_REQ;
        ST_DRAIN:         state_d = ST_DRAIN;
        default:          state_d = ST_REQ;
      endcase
    end
  end

  // State and fetch pointer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      next_ptr_q <= RESET_PTR;
    end else begin
      state_q    <= state_d;
      next_ptr_q <= next_ptr_d;
    end
  end

  inst_prefetch_queue_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (fifo_push),
    .push_entry (push_entry),
    .pop        (pop_fire),
    .flush      (redirect),
    .head       (head),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .count      (fifo_count)
  );

endmodule

// File: tb/tb_inst_prefetch_queue.sv
// tb/tb_inst_prefetch_queue.sv - randomized bench with a queue-level model of the prefetcher
module tb_inst_prefetch_queue;
  import inst_prefetch_queue_pkg::*;

  localparam int              W     = WORD_SIZE;
  localparam int              DEPTH = 4;
  localparam int              STEP  = 1;
  localparam logic [W-1:0]    RP    = '0;
  localparam logic [W-1:0]    BASE  = 32'hA000_0000;

  logic           clk;
  logic           rst;
  logic [0:W-1]   fetch_ptr;
  logic           fetch_enable;
  logic           fetch_busy;
  logic [W-1:0]   fetch_inst;
  logic           redirect;
  logic [W-1:0]   redirect_ptr;
  logic [W-1:0]   inst_out;
  logic [W-1:0]   inst_ptr;
  logic           inst_valid;
  logic           inst_ready;

  inst_prefetch_queue #(
    .DEPTH(DEPTH), .PTR_STEP(STEP), .RESET_PTR(RP)
  ) dut (
    .clk(clk), .rst(rst), .fetch_ptr(fetch_ptr), .fetch_enable(fetch_enable),
    .fetch_busy(fetch_busy), .fetch_inst(fetch_inst), .redirect(redirect),
    .redirect_ptr(redirect_ptr), .inst_out(inst_out), .inst_ptr(inst_ptr),
    .inst_valid(inst_valid), .inst_ready(inst_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state: queued pointers, expected next fetch target, and the fetch responder.
  logic [W-1:0] mq[$];
  logic [W-1:0] exp_fetch;
  bit           outstanding;
  bit           live;
  logic [W-1:0] f_ptr;
  int           cnt;
  bit           rand_busy;
  logic [W-1:0] pop_log[$];
  logic [W-1:0] pop_inst_log[$];
  logic [W-1:0] fetch_log[$];
  logic [W-1:0] seen_ptr, seen_inst;
  int           errors, checks;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_logs();
    pop_log.delete();
    pop_inst_log.delete();
    fetch_log.delete();
  endtask

  // Apply the rules for the posedge that just passed, using the inputs it saw.
  task automatic model_edge();
    bit capture;
    capture = outstanding && !fetch_busy;
    if (rst) begin
      mq.delete();
      exp_fetch = RP;
      live = 0;
      if (capture) outstanding = 0;
      return;
    end
    if (redirect) begin
      mq.delete();
      exp_fetch = redirect_ptr;
      live = 0;
    end else begin
      if (mq.size() > 0 && inst_ready) begin
        void'(mq.pop_front());
        pop_log.push_back(seen_ptr);
        pop_inst_log.push_back(seen_inst);
      end
      if (capture && live) begin
        mq.push_back(f_ptr);
        exp_fetch = f_ptr + W'(STEP);
      end
    end
    if (capture) outstanding = 0;
    if (mq.size() > DEPTH) chk("queue_overflow", 32'(mq.size()), 32'(DEPTH));
  endtask

  task automatic check_outputs();
    if (rst) begin
      chk("rst_fetch_enable", 32'(fetch_enable), 32'd0);
      chk("rst_inst_valid", 32'(inst_valid), 32'd0);
      chk("rst_fetch_ptr", fetch_ptr, RP);
      chk("rst_inst_out", inst_out, 32'd0);
      chk("rst_inst_ptr", inst_ptr, 32'd0);
      return;
    end
    chk("inst_valid", 32'(inst_valid), 32'(mq.size() > 0));
    if (mq.size() > 0) begin
      chk("inst_ptr", inst_ptr, mq[0]);
      chk("inst_out", inst_out, BASE + mq[0]);
    end
    chk("req_while_in_flight", 32'(fetch_enable && outstanding), 32'd0);
    if (fetch_enable) begin
      chk("fetch_ptr", fetch_ptr, exp_fetch);
      chk("req_with_room", 32'(mq.size() < DEPTH), 32'd1);
    end
    seen_ptr  = inst_ptr;
    seen_inst = inst_out;
  endtask

  // Fetch responder: busy for a few cycles after a request, then returns BASE+ptr.
  task automatic fetch_drive();
    if (cnt > 0) begin
      cnt--;
      if (cnt == 0) begin
        fetch_busy = 1'b0;
        fetch_inst = BASE + f_ptr;
      end
    end else if (fetch_enable && !outstanding && !rst) begin
      fetch_log.push_back(fetch_ptr);
      f_ptr       = fetch_ptr;
      outstanding = 1;
      live        = 1;
      fetch_busy  = 1'b1;
      cnt         = rand_busy ? int'($urandom_range(1, 3)) : 2;
      fetch_inst  = $urandom;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    model_edge();
    check_outputs();
    fetch_drive();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < 10 && (i < 2 || outstanding); i++) tick();
    rst = 1'b0;
  endtask

  task automatic wait_pops(input int n);
    for (int i = 0; i < 200 && pop_log.size() < n; i++) tick();
    chk("pops_reached", 32'(pop_log.size() >= n), 32'd1);
  endtask

  initial begin
    errors = 0; checks = 0;
    rst = 1'b1; fetch_busy = 1'b0; fetch_inst = '0; redirect = 1'b0;
    redirect_ptr = '0; inst_ready = 1'b0;
    outstanding = 0; live = 0; cnt = 0; rand_busy = 0; exp_fetch = RP;
    seen_ptr = '0; seen_inst = '0;
    #1;
    check_outputs();
    tick(); tick();
    rst = 1'b0;

    // Streaming with decode always ready.
    inst_ready = 1'b1;
    clear_logs();
    wait_pops(3);
    for (int i = 0; i < 3; i++) begin
      if (pop_log.size() > i) begin
        chk("t1_pop_ptr", pop_log[i], 32'(i));
        chk("t1_pop_inst", pop_inst_log[i], 32'hA000_0000 + 32'(i));
        chk("t1_fetch_ptr", fetch_log[i], 32'(i));
      end
    end

    // Decode stalled: exactly DEPTH fetches, then a single pop re-enables one.
    inst_ready = 1'b0;
    do_reset();
    clear_logs();
    for (int i = 0; i < 40; i++) tick();
    chk("t2_fetch_count", 32'(fetch_log.size()), 32'd4);
    for (int i = 0; i < 4; i++) if (fetch_log.size() > i) chk("t2_fetch_ptr", fetch_log[i], 32'(i));
    chk("t2_valid_full", 32'(inst_valid), 32'd1);
    chk("t2_head_ptr", inst_ptr, 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t2_stalled", 32'(fetch_enable), 32'd0);
    end
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("t2_refetch_count", 32'(fetch_log.size()), 32'd5);
    if (fetch_log.size() > 4) chk("t2_refetch_ptr", fetch_log[4], 32'd4);

    // Redirect while waiting on ptr 2.
    inst_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 100 && !(outstanding && live && f_ptr == 2 && cnt == 1); i++) tick();
    chk("t3_reached_wait", 32'(outstanding && f_ptr == 2), 32'd1);
    redirect = 1'b1; redirect_ptr = 32'd20;
    tick();
    redirect = 1'b0;
    chk("t3_valid_dropped", 32'(inst_valid), 32'd0);
    clear_logs();
    wait_pops(2);
    if (pop_log.size() > 1) begin
      chk("t3_pop0", pop_log[0], 32'd20);
      chk("t3_pop1", pop_log[1], 32'd21);
      chk("t3_fetch0", fetch_log[0], 32'd20);
      chk("t3_fetch1", fetch_log[1], 32'd21);
    end

    // Redirect coinciding with a valid pop and a capture.
    inst_ready = 1'b0;
    for (int i = 0; i < 100 && !(mq.size() >= 1 && outstanding && live && !fetch_busy); i++) tick();
    chk("t4_reached", 32'(mq.size() >= 1 && outstanding && !fetch_busy), 32'd1);
    inst_ready = 1'b1; redirect = 1'b1; redirect_ptr = 32'd100;
    tick();
    redirect = 1'b0;
    chk("t4_valid_dropped", 32'(inst_valid), 32'd0);
    clear_logs();
    wait_pops(1);
    if (pop_log.size() > 0) begin
      chk("t4_pop0", pop_log[0], 32'd100);
      chk("t4_fetch0", fetch_log[0], 32'd100);
    end

    // Pointer wrap.
    redirect = 1'b1; redirect_ptr = 32'hFFFF_FFFE;
    tick();
    redirect = 1'b0;
    clear_logs();
    wait_pops(4);
    if (pop_log.size() > 3) begin
      chk("t5_pop0", pop_log[0], 32'hFFFF_FFFE);
      chk("t5_pop1", pop_log[1], 32'hFFFF_FFFF);
      chk("t5_pop2", pop_log[2], 32'h0000_0000);
      chk("t5_pop2_inst", pop_inst_log[2], 32'hA000_0000);
      chk("t5_pop3", pop_log[3], 32'h0000_0001);
    end

    // Asynchronous reset mid-wait.
    for (int i = 0; i < 100 && !(outstanding && live && cnt == 1); i++) tick();
    chk("t6_reached_wait", 32'(outstanding && cnt == 1), 32'd1);
    #2 rst = 1'b1;
    #1;
    mq.delete(); live = 0; exp_fetch = RP;
    check_outputs();
    for (int i = 0; i < 10 && (i < 2 || outstanding); i++) tick();
    rst = 1'b0;
    clear_logs();
    wait_pops(1);
    if (pop_log.size() > 0) begin
      chk("t6_fetch0", fetch_log[0], RP);
      chk("t6_pop0", pop_log[0], RP);
    end

    // Randomized traffic: decode backpressure, busy lengths and redirects.
    rand_busy = 1;
    for (int i = 0; i < 3000; i++) begin
      inst_ready = ($urandom_range(0, 3) != 0);
      if (!redirect && $urandom_range(0, 29) == 0) begin
        redirect = 1'b1;
        redirect_ptr = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFD : 32'($urandom);
      end else begin
        redirect = 1'b0;
      end
      tick();
    end
    redirect = 1'b0;
    for (int i = 0; i < 10; i++) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
